// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - shared types and constants for the MDR/RAM access sequencer
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WLOAD = 3'd1,
        WRITE = 3'd2,
        RWAIT = 3'd3,
        RCAPT = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    // MDR control word: [2] load from bus, [1] load from RAM, [0] drive RAM
    localparam logic [2:0] MDR_CTRL_NONE = 3'b000;
    localparam logic [2:0] MDR_CTRL_BUS  = 3'b100;
    localparam logic [2:0] MDR_CTRL_RAM  = 3'b010;
    localparam logic [2:0] MDR_CTRL_DRV  = 3'b001;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT_DATA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-port round-robin winner select, purely combinational
module rr_arbiter_2
    import mem_seq_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = PORT_FETCH;
        case (req)
            2'b01:   winner = PORT_FETCH;
            2'b10:   winner = PORT_DATA;
            // Contention: whoever was not served last goes next
            2'b11:   winner = (last_served == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
            default: winner = PORT_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - arbitrates fetch/data requesters and sequences MDR and RAM strobes
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int RAM_RD_LAT    = 2,
    parameter int RAM_WR_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] req,
    input  logic [1:0] req_we,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic [2:0] mdr_ctrl,
    output logic       ram_en,
    output logic       ram_we,
    output logic       busy
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (RAM_RD_LAT < 1 || RAM_RD_LAT > CNT_MAX) begin : g_bad_rd_lat
        $error("mem_access_sequencer: RAM_RD_LAT out of range for CNT_W");
    end
    if (RAM_WR_CYCLES < 1 || RAM_WR_CYCLES > CNT_MAX) begin : g_bad_wr_cycles
        $error("mem_access_sequencer: RAM_WR_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RAM_RD_LAT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(RAM_WR_CYCLES - 1);

    seq_state_t       state, state_nxt;
    logic [1:0]       grant_q, grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_served, last_served_nxt;

    logic             arb_winner;
    logic             arb_valid;

    rr_arbiter_2 u_arb (
        .req         (req),
        .last_served (last_served),
        .winner      (arb_winner),
        .valid       (arb_valid)
    );

    // last_served resets to the data port so fetch wins the first contention
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            grant_q     <= 2'b00;
            cnt         <= '0;
            last_served <= PORT_DATA;
        end else begin
            state       <= state_nxt;
            grant_q     <= grant_nxt;
            cnt         <= cnt_nxt;
            last_served <= last_served_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_nxt       = grant_q;
        cnt_nxt         = cnt;
        last_served_nxt = last_served;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    grant_nxt       = port_onehot(arb_winner);
                    last_served_nxt = arb_winner;
                    cnt_nxt         = '0;
                    state_nxt       = req_we[arb_winner] ? WLOAD : RWAIT;
                end
            end
            WLOAD: begin
                cnt_nxt   = '0;
                state_nxt = WRITE;
            end
            WRITE: begin
                if (cnt == WR_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RWAIT: begin
                if (cnt == RD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = RCAPT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RCAPT: begin
                state_nxt = DONE;
            end
            DONE: begin
                grant_nxt = 2'b00;
                state_nxt = IDLE;
            end
            default: begin
                grant_nxt = 2'b00;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only; req never reaches them directly
    always_comb begin
        done     = 2'b00;
        mdr_ctrl = MDR_CTRL_NONE;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        case (state)
            WLOAD: mdr_ctrl = MDR_CTRL_BUS;
            WRITE: begin
                mdr_ctrl = MDR_CTRL_DRV;
                ram_en   = 1'b1;
                ram_we   = 1'b1;
            end
            RWAIT: ram_en   = 1'b1;
            RCAPT: mdr_ctrl = MDR_CTRL_RAM;
            DONE:  done     = grant_q;
            default: begin
                done     = 2'b00;
                mdr_ctrl = MDR_CTRL_NONE;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - scoreboard bench for two sequencer configurations
module tb_mem_access_sequencer;

    typedef struct {
        logic [1:0] port;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n_v [2];
    logic [1:0] req_v   [2];
    logic [1:0] we_v    [2];
    logic [1:0] grant_o [2];
    logic [1:0] done_o  [2];
    logic [2:0] mdr_o   [2];
    logic       ram_en_o[2];
    logic       ram_we_o[2];
    logic       busy_o  [2];

    ev_t        exp_g[2][$];
    ev_t        exp_d[2][$];
    logic [1:0] prev_grant[2];

    int cyc     = 0;
    int n_check = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_sequencer #(.RAM_RD_LAT(2), .RAM_WR_CYCLES(1), .CNT_W(4)) u_dut_a (
        .Clk(clk), .Rst_n(rst_n_v[0]), .req(req_v[0]), .req_we(we_v[0]),
        .grant(grant_o[0]), .done(done_o[0]), .mdr_ctrl(mdr_o[0]),
        .ram_en(ram_en_o[0]), .ram_we(ram_we_o[0]), .busy(busy_o[0])
    );

    mem_access_sequencer #(.RAM_RD_LAT(5), .RAM_WR_CYCLES(3), .CNT_W(4)) u_dut_b (
        .Clk(clk), .Rst_n(rst_n_v[1]), .req(req_v[1]), .req_we(we_v[1]),
        .grant(grant_o[1]), .done(done_o[1]), .mdr_ctrl(mdr_o[1]),
        .ram_en(ram_en_o[1]), .ram_we(ram_we_o[1]), .busy(busy_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_check++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic check_idle_outputs(input int s, input string tag);
        check($sformatf("%s_grant%0d", tag, s), grant_o[s], 0);
        check($sformatf("%s_done%0d", tag, s), done_o[s], 0);
        check($sformatf("%s_mdr%0d", tag, s), mdr_o[s], 0);
        check($sformatf("%s_ram_en%0d", tag, s), ram_en_o[s], 0);
        check($sformatf("%s_ram_we%0d", tag, s), ram_we_o[s], 0);
        check($sformatf("%s_busy%0d", tag, s), busy_o[s], 0);
    endtask

    // Monitor: invariants every cycle, grant/done events popped from the scoreboard
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            check($sformatf("inv_grant_onehot%0d", s), $onehot0(grant_o[s]), 1);
            check($sformatf("inv_mdr_onehot%0d", s), $onehot0(mdr_o[s]), 1);
            check($sformatf("inv_we_implies%0d", s),
                  !ram_we_o[s] || (ram_en_o[s] && mdr_o[s] == 3'b001), 1);
            if (grant_o[s] != 2'b00 && prev_grant[s] == 2'b00) begin
                if (exp_g[s].size() == 0) begin
                    check($sformatf("grant_unexpected%0d", s), grant_o[s], 0);
                end else begin
                    ev_t e;
                    e = exp_g[s].pop_front();
                    check($sformatf("grant_port%0d", s), grant_o[s], e.port);
                    check($sformatf("grant_cycle%0d", s), cyc, e.cyc);
                end
            end
            if (done_o[s] != 2'b00) begin
                if (exp_d[s].size() == 0) begin
                    check($sformatf("done_unexpected%0d", s), done_o[s], 0);
                end else begin
                    ev_t e;
                    e = exp_d[s].pop_front();
                    check($sformatf("done_port%0d", s), done_o[s], e.port);
                    check($sformatf("done_cycle%0d", s), cyc, e.cyc);
                end
            end
            prev_grant[s] = grant_o[s];
        end
    end

    // Single transaction with cycle-by-cycle strobe expectations
    task automatic txn(input int s, input int port, input bit we, input bit flip);
        int rd, wr, dl, t0;
        logic [1:0] oh;
        bit wr_phase;
        rd = (s == 1) ? 5 : 2;
        wr = (s == 1) ? 3 : 1;
        dl = we ? wr + 2 : rd + 2;
        oh = (port == 1) ? 2'b10 : 2'b01;
        @(negedge clk);
        t0 = cyc;
        req_v[s][port] = 1'b1;
        we_v[s][port]  = we;
        exp_g[s].push_back('{port: oh, cyc: t0 + 1});
        exp_d[s].push_back('{port: oh, cyc: t0 + dl});
        for (int k = 1; k <= dl + 1; k++) begin
            @(negedge clk);
            wr_phase = we && k >= 2 && k <= wr + 1;
            check($sformatf("ram_en%0d_k%0d", s, k), ram_en_o[s], we ? wr_phase : (k <= rd));
            check($sformatf("ram_we%0d_k%0d", s, k), ram_we_o[s], wr_phase);
            check($sformatf("mdr%0d_k%0d", s, k), mdr_o[s],
                  we ? ((k == 1) ? 3'b100 : (wr_phase ? 3'b001 : 3'b000))
                     : ((k == rd + 1) ? 3'b010 : 3'b000));
            check($sformatf("busy%0d_k%0d", s, k), busy_o[s], k <= dl);
            check($sformatf("grant%0d_k%0d", s, k), grant_o[s], (k <= dl) ? oh : 2'b00);
            if (flip && k == 1) begin
                req_v[s][port] = 1'b0;
                we_v[s][port]  = ~we;
            end
            if (k == dl) begin
                req_v[s][port] = 1'b0;
                we_v[s][port]  = 1'b0;
            end
        end
    endtask

    // Both ports read continuously on instance A, two transactions each
    task automatic contention();
        int t0, c0, c1;
        @(negedge clk);
        t0 = cyc;
        req_v[0] = 2'b11;
        we_v[0]  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            exp_g[0].push_back('{port: (i % 2 == 0) ? 2'b01 : 2'b10, cyc: t0 + 1 + 5 * i});
            exp_d[0].push_back('{port: (i % 2 == 0) ? 2'b01 : 2'b10, cyc: t0 + 4 + 5 * i});
        end
        c0 = 0;
        c1 = 0;
        for (int n = 0; n < 40 && (c0 < 2 || c1 < 2); n++) begin
            @(negedge clk);
            if (done_o[0][0]) begin
                c0++;
                if (c0 == 2) req_v[0][0] = 1'b0;
            end
            if (done_o[0][1]) begin
                c1++;
                if (c1 == 2) req_v[0][1] = 1'b0;
            end
        end
        req_v[0] = 2'b00;
        check("contention_done_count", c0 + c1, 4);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            rst_n_v[s]    = 1'b0;
            req_v[s]      = 2'b00;
            we_v[s]       = 2'b00;
            prev_grant[s] = 2'b00;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset");
        rst_n_v[0] = 1'b1;
        rst_n_v[1] = 1'b1;

        txn(0, 0, 1'b0, 1'b0);
        txn(0, 1, 1'b1, 1'b0);
        txn(0, 1, 1'b0, 1'b1);
        txn(0, 0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        req_v[0] = 2'b10;
        we_v[0]  = 2'b10;
        exp_g[0].push_back('{port: 2'b10, cyc: cyc + 1});
        repeat (2) @(negedge clk);
        check("pre_reset_ram_we", ram_we_o[0], 1);
        #2 rst_n_v[0] = 1'b0;
        #1 check_idle_outputs(0, "async_reset");
        req_v[0] = 2'b00;
        we_v[0]  = 2'b00;
        exp_d[0].delete();
        repeat (2) @(negedge clk);
        rst_n_v[0] = 1'b1;
        contention();

        txn(1, 0, 1'b0, 1'b0);
        txn(1, 1, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_grant_empty_a", exp_g[0].size(), 0);
        check("sb_done_empty_a", exp_d[0].size(), 0);
        check("sb_grant_empty_b", exp_g[1].size(), 0);
        check("sb_done_empty_b", exp_d[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
